// File: rtl/chunked_seq_addsub.sv
// Multi-cycle adder/subtractor: processes CHUNK bits per clock, LSB chunk first,
// with the inter-chunk carry held in a register. Reports cout, signed overflow and zero.
module chunked_seq_addsub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

  generate
    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
      $error("chunked_seq_addsub: WIDTH must be a multiple of CHUNK");
    end
  endgenerate

  // Handshake: a transfer happens on a rising edge where valid && ready are both high.
  // in_ready depends on state only; out_valid and results stay stable until out_ready.
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             a_msb;
  logic             b_msb;
  logic             carry;
  logic [IW-1:0]    idx;
  logic [CHUNK:0]   chunk_sum;
  logic [WIDTH-1:0] next_sum;

  assign in_ready = (state == IDLE);

  // Operands shift right each cycle so the active chunk is always at bit 0;
  // the result shifts in from the top and lands in place after NCH cycles.
  always_comb begin
    chunk_sum = {1'b0, a_r[CHUNK-1:0]} + {1'b0, b_r[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry};
    next_sum  = (sum >> CHUNK) | (WIDTH'(chunk_sum[CHUNK-1:0]) << (WIDTH - CHUNK));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
      idx       <= '0;
      carry     <= 1'b0;
      a_r       <= '0;
      b_r       <= '0;
      a_msb     <= 1'b0;
      b_msb     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r   <= a;
            b_r   <= b ^ {WIDTH{sub}};
            carry <= sub | cin;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1] ^ sub;
            idx   <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          sum   <= next_sum;
          carry <= chunk_sum[CHUNK];
          a_r   <= a_r >> CHUNK;
          b_r   <= b_r >> CHUNK;
          idx   <= idx + 1'b1;
          if (idx == IW'(NCH - 1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            cout      <= chunk_sum[CHUNK];
            ovf       <= (a_msb == b_msb) && (next_sum[WIDTH-1] != a_msb);
            zero      <= (next_sum == '0);
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chunked_seq_addsub.sv
// Bench for chunked_seq_addsub: three instances (16/4, 8/8, 32/8) share one driver
// through a select, with directed vector tables, corner sequences and random ops.
module tb_chunked_seq_addsub;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, out_ready;
  logic [31:0] a, b;
  logic        cin, sub;
  int          sel;

  logic        iv16, ir16, ov16, or16, c16, f16, z16;
  logic [15:0] s16;
  logic        iv8, ir8, ov8, or8, c8, f8, z8;
  logic [7:0]  s8;
  logic        iv32, ir32, ov32, or32, c32, f32, z32;
  logic [31:0] s32;

  logic        m_in_ready, m_out_valid, m_cout, m_ovf, m_zero;
  logic [31:0] m_sum;

  int n_checks = 0;
  int n_fail   = 0;
  logic [34:0] exp_q[$];

  always #5 clk = ~clk;

  assign iv16 = in_valid && (sel == 0);
  assign or16 = out_ready && (sel == 0);
  assign iv8  = in_valid && (sel == 1);
  assign or8  = out_ready && (sel == 1);
  assign iv32 = in_valid && (sel == 2);
  assign or32 = out_ready && (sel == 2);

  chunked_seq_addsub #(.WIDTH(16), .CHUNK(4)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a[15:0]), .b(b[15:0]),
    .cin(cin), .sub(sub), .out_valid(ov16), .out_ready(or16), .sum(s16), .cout(c16),
    .ovf(f16), .zero(z16));

  chunked_seq_addsub #(.WIDTH(8), .CHUNK(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a[7:0]), .b(b[7:0]),
    .cin(cin), .sub(sub), .out_valid(ov8), .out_ready(or8), .sum(s8), .cout(c8),
    .ovf(f8), .zero(z8));

  chunked_seq_addsub #(.WIDTH(32), .CHUNK(8)) u32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(ov32), .out_ready(or32), .sum(s32), .cout(c32),
    .ovf(f32), .zero(z32));

  always_comb begin
    m_in_ready = ir16; m_out_valid = ov16; m_sum = {16'h0, s16};
    m_cout = c16; m_ovf = f16; m_zero = z16;
    if (sel == 1) begin
      m_in_ready = ir8; m_out_valid = ov8; m_sum = {24'h0, s8};
      m_cout = c8; m_ovf = f8; m_zero = z8;
    end else if (sel == 2) begin
      m_in_ready = ir32; m_out_valid = ov32; m_sum = s32;
      m_cout = c32; m_ovf = f32; m_zero = z32;
    end
  end

  typedef struct {
    int          s;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int nch_of(input int s);
    return (s == 1) ? 1 : 4;
  endfunction

  function automatic int width_of(input int s);
    return (s == 0) ? 16 : ((s == 1) ? 8 : 32);
  endfunction

  // Reference: plain full-width arithmetic, independent of the chunking.
  function automatic logic [34:0] model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                        input logic ci, input logic sb);
    logic [63:0] mask, bb, full;
    logic [31:0] s;
    logic        co, ov;
    mask = (64'd1 << w) - 64'd1;
    bb   = sb ? ((~{32'h0, bv}) & mask) : ({32'h0, bv} & mask);
    full = ({32'h0, av} & mask) + bb + (sb ? 64'd1 : {63'd0, ci});
    s    = full[31:0] & mask[31:0];
    co   = full[w];
    ov   = (av[w-1] == bb[w-1]) && (s[w-1] != av[w-1]);
    return {co, ov, (s == 32'h0), s};
  endfunction

  // One complete operation on instance s; poke drives a rival in_valid while stalled.
  task automatic run_op(input int s, input logic [31:0] av, input logic [31:0] bv,
                        input logic ci, input logic sb, input logic [34:0] exp,
                        input int pre_stall, input int post_stall, input bit poke);
    int          guard;
    int          lat;
    logic [34:0] e;
    sel = s;
    for (int i = 0; i < pre_stall; i++) tick();
    a = av; b = bv; cin = ci; sub = sb; in_valid = 1'b1;
    guard = 0;
    while (!m_in_ready && guard < 50) begin
      tick();
      guard++;
    end
    check("accept_ready", {63'd0, m_in_ready}, 64'd1);
    tick();
    exp_q.push_back(exp);
    in_valid = 1'b0;
    a = ~av; b = ~bv; cin = ~ci; sub = ~sb;
    lat = 0;
    while (!m_out_valid && lat < nch_of(s) + 10) begin
      tick();
      lat++;
    end
    check("latency", 64'(lat), 64'(nch_of(s)));
    for (int i = 0; i < post_stall; i++) begin
      if (poke) begin
        in_valid = 1'b1;
        a = 32'h0F0F_0F0F; b = 32'h1234_5678;
      end
      tick();
      check("stall_valid", {63'd0, m_out_valid}, 64'd1);
      check("stall_in_ready", {63'd0, m_in_ready}, 64'd0);
      check("stall_result", {29'd0, m_cout, m_ovf, m_zero, m_sum}, {29'd0, exp});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    e = exp_q.pop_front();
    check("result", {29'd0, m_cout, m_ovf, m_zero, m_sum}, {29'd0, e});
    tick();
    out_ready = 1'b0;
    check("post_valid", {63'd0, m_out_valid}, 64'd0);
    check("post_in_ready", {63'd0, m_in_ready}, 64'd1);
    if (poke) begin
      tick();
      check("no_stray_op", {63'd0, m_in_ready}, 64'd1);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rb;
    logic        rc, rs;
    int          w;

    //        s  a             b             cin   sub   sum           cout  ovf   zero
    vecs[0]  = '{0, 32'hFFFF,     32'h0001,     1'b0, 1'b0, 32'h0000,     1'b1, 1'b0, 1'b1};
    vecs[1]  = '{0, 32'h8000,     32'h0001,     1'b0, 1'b1, 32'h7FFF,     1'b1, 1'b1, 1'b0};
    vecs[2]  = '{0, 32'h0003,     32'h0005,     1'b0, 1'b1, 32'hFFFE,     1'b0, 1'b0, 1'b0};
    vecs[3]  = '{0, 32'h1234,     32'h4321,     1'b1, 1'b0, 32'h5556,     1'b0, 1'b0, 1'b0};
    vecs[4]  = '{0, 32'h0005,     32'h0005,     1'b1, 1'b1, 32'h0000,     1'b1, 1'b0, 1'b1};
    vecs[5]  = '{0, 32'h7FFF,     32'h0001,     1'b0, 1'b0, 32'h8000,     1'b0, 1'b1, 1'b0};
    vecs[6]  = '{0, 32'h8000,     32'h8000,     1'b0, 1'b0, 32'h0000,     1'b1, 1'b1, 1'b1};
    vecs[7]  = '{0, 32'hFFFF,     32'hFFFF,     1'b1, 1'b0, 32'hFFFF,     1'b1, 1'b0, 1'b0};
    vecs[8]  = '{0, 32'h0000,     32'h0001,     1'b0, 1'b1, 32'hFFFF,     1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1, 32'h00FF,     32'h0001,     1'b0, 1'b0, 32'h0000,     1'b1, 1'b0, 1'b1};
    vecs[10] = '{2, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
    vecs[11] = '{2, 32'h0FFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 32'h1000_0001, 1'b0, 1'b0, 1'b0};

    sel = 0; rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("reset_out_valid", {63'd0, ov16}, 64'd0);
    check("reset_sum", {48'd0, s16}, 64'd0);
    check("reset_flags", {61'd0, c16, f16, z16}, 64'd0);
    check("reset_in_ready", {63'd0, ir16}, 64'd1);

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
             {vecs[i].cout, vecs[i].ovf, vecs[i].zero, vecs[i].sum}, i % 2, i % 3, 1'b0);
    end

    // Backpressure: 5 stalled cycles with a rival request that must be ignored.
    run_op(0, 32'h00FF, 32'h0F01, 1'b0, 1'b0, {1'b0, 1'b0, 1'b0, 32'h1000}, 0, 5, 1'b1);

    // Reset after two chunks: the operation is abandoned with no result.
    sel = 0;
    a = 32'h1111; b = 32'h2222; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midreset_out_valid", {63'd0, ov16}, 64'd0);
    check("midreset_sum", {48'd0, s16}, 64'd0);
    check("midreset_in_ready", {63'd0, ir16}, 64'd1);
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
        tick();
        if (ov16) seen++;
      end
      check("midreset_no_result", 64'(seen), 64'd0);
    end
    run_op(0, 32'h1234, 32'h4321, 1'b1, 1'b0, {1'b0, 1'b0, 1'b0, 32'h5556}, 0, 1, 1'b0);

    // Random ops on the single-chunk and multi-chunk instances.
    for (int s = 1; s <= 2; s++) begin
      w = width_of(s);
      for (int n = 0; n < 1000; n++) begin
        ra = $urandom();
        rb = $urandom();
        if (w == 8) begin
          ra = ra & 32'hFF;
          rb = rb & 32'hFF;
        end
        rc = 1'($urandom_range(0, 1));
        rs = 1'($urandom_range(0, 1));
        run_op(s, ra, rb, rc, rs, model(w, ra, rb, rc, rs),
               $urandom_range(0, 2), $urandom_range(0, 3), 1'b0);
      end
    end

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
